// File: rtl/fp_result_unpacker.sv
// fp_result_unpacker: drains packed FP32 / 2xBF16 result words from a small
// input FIFO and serialises them into scalar FP32 beats on a valid/ready port.
// Optional build macro: FP_UNPACK_NAN_CANON_EN replaces every NaN output beat
// with the canonical quiet NaN 32'h7FC00000.

package fp_result_unpacker_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_fmt_e;
endpackage

module fp_result_unpacker #(
  parameter int unsigned DEPTH      = 2,
  parameter bit          LANE_ORDER = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  fp_result_unpacker_pkg::fp_fmt_e     in_fmt,
  input  logic [31:0]                         in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [31:0]                         out_data,
  output logic                                out_lane,
  output logic                                out_last,
  output logic [$clog2(DEPTH+1)-1:0]          fifo_count
);
  import fp_result_unpacker_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

  // Storage keeps only "is a BF16 pair", since every non-FP32 format is a pair.
  logic [31:0]   mem_data [DEPTH];
  logic          mem_pair [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push, pop, empty, load;
  logic [31:0]   head_data;
  logic          head_pair;
  logic [15:0]   first_half, second_half;

  state_e        state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_lane_q, out_lane_d;
  logic          out_last_q, out_last_d;

  // Quiet-NaN canonicalisation of an already widened FP32 beat.
  function automatic logic [31:0] canon(input logic [31:0] x);
`ifdef FP_UNPACK_NAN_CANON_EN
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
    return x;
  endfunction

  // Exact BF16 -> FP32 widening: the BF16 bits become the upper half.
  function automatic logic [31:0] widen(input logic [15:0] h);
    return {h, 16'h0000};
  endfunction

  assign in_ready   = (count_q < CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = in_valid & in_ready;
  assign load       = ~out_valid_q | out_ready;
  assign head_data  = mem_data[rd_ptr_q];
  assign head_pair  = mem_pair[rd_ptr_q];
  assign first_half  = LANE_ORDER ? head_data[31:16] : head_data[15:0];
  assign second_half = LANE_ORDER ? head_data[15:0]  : head_data[31:16];

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;
  assign out_last   = out_last_q;
  assign fifo_count = count_q;

  // FIFO storage write; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_pair[wr_ptr_q] <= (in_fmt != FP32);
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Beat sequencing: choose what the output register loads and when the head pops.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_last_d  = out_last_q;
    if (load) begin
      unique case (state_q)
        StIdle, StFirst: begin
          if (empty) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end else if (!head_pair) begin
            out_valid_d = 1'b1;
            out_data_d  = canon(head_data);
            out_lane_d  = 1'b0;
            out_last_d  = 1'b1;
            pop         = 1'b1;
            state_d     = StFirst;
          end else begin
            // Pair stays at the head until its second lane is loaded.
            out_valid_d = 1'b1;
            out_data_d  = canon(widen(first_half));
            out_lane_d  = LANE_ORDER;
            out_last_d  = 1'b0;
            state_d     = StSecond;
          end
        end
        StSecond: begin
          out_valid_d = 1'b1;
          out_data_d  = canon(widen(second_half));
          out_lane_d  = ~LANE_ORDER;
          out_last_d  = 1'b1;
          pop         = 1'b1;
          state_d     = StFirst;
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      endcase
    end
  end

  // FSM state and registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_fp_result_unpacker.sv
// Bench for fp_result_unpacker: two instances (DEPTH=2/low lane first and
// DEPTH=4/high lane first) share data, format and out_ready; each has its
// own in_valid so their handshakes stay independent.
module tb_fp_result_unpacker;
  import fp_result_unpacker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v0, v1, in_ready0, in_ready1, out_ready;
  fp_fmt_e     in_fmt;
  logic [31:0] in_data;
  logic        out_valid0, out_lane0, out_last0;
  logic        out_valid1, out_lane1, out_last1;
  logic [31:0] out_data0, out_data1;
  logic [1:0]  fc0;
  logic [2:0]  fc1;

  fp_result_unpacker #(.DEPTH(2), .LANE_ORDER(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(in_ready0), .in_fmt(in_fmt),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_lane(out_lane0), .out_last(out_last0), .fifo_count(fc0)
  );

  fp_result_unpacker #(.DEPTH(4), .LANE_ORDER(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1), .in_fmt(in_fmt),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_lane(out_lane1), .out_last(out_last1), .fifo_count(fc1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_rdy = 1'b0;

  logic [34:0] acc0[$], acc1[$];   // accepted words {fmt, data}
  logic [33:0] obs0[$], obs1[$];   // observed beats {lane, last, data}
  logic [33:0] exp_q[$];
  int          ts0[$];

  // Record handshakes at the clock edge (pre-update values).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (v0 && in_ready0) acc0.push_back({in_fmt, in_data});
      if (v1 && in_ready1) acc1.push_back({in_fmt, in_data});
      if (out_valid0 && out_ready) begin
        obs0.push_back({out_lane0, out_last0, out_data0});
        ts0.push_back(cyc);
      end
      if (out_valid1 && out_ready) obs1.push_back({out_lane1, out_last1, out_data1});
    end
  end

  always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

  function automatic logic [31:0] m_canon(input logic [31:0] x);
`ifdef FP_UNPACK_NAN_CANON_EN
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
    return x;
  endfunction

  // Reference: every word expands into its beats, independent of timing.
  task automatic build_exp(input int inst);
    logic [34:0] w;
    logic [15:0] lo, hi;
    bit          hi_first;
    int          n;
    exp_q.delete();
    hi_first = (inst == 1);
    n = (inst == 0) ? acc0.size() : acc1.size();
    for (int i = 0; i < n; i++) begin
      w  = (inst == 0) ? acc0[i] : acc1[i];
      lo = w[15:0];
      hi = w[31:16];
      if (w[34:32] == 3'd0) begin
        exp_q.push_back({1'b0, 1'b1, m_canon(w[31:0])});
      end else if (hi_first) begin
        exp_q.push_back({1'b1, 1'b0, m_canon({hi, 16'h0})});
        exp_q.push_back({1'b0, 1'b1, m_canon({lo, 16'h0})});
      end else begin
        exp_q.push_back({1'b0, 1'b0, m_canon({lo, 16'h0})});
        exp_q.push_back({1'b1, 1'b1, m_canon({hi, 16'h0})});
      end
    end
  endtask

  task automatic clear_logs();
    acc0.delete(); acc1.delete(); obs0.delete(); obs1.delete(); ts0.delete();
  endtask

  task automatic finish_push(input int budget, output bit ok);
    bit a0, a1;
    for (int c = 0; c < budget && (v0 || v1); c++) begin
      a0 = v0 & in_ready0;
      a1 = v1 & in_ready1;
      @(negedge clk);
      if (a0) v0 = 1'b0;
      if (a1) v1 = 1'b0;
    end
    ok = !v0 && !v1;
  endtask

  task automatic push(input logic [31:0] d, input fp_fmt_e f, input int budget, output bit ok);
    in_data = d;
    in_fmt  = f;
    v0 = 1'b1;
    v1 = 1'b1;
    finish_push(budget, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; out_ready = 1'b0; in_data = '0; in_fmt = FP32;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid0, out_data0, out_lane0, out_last0, fc0} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_dut0 got v=%b d=%h l=%b last=%b fc=%0d want all zero",
               out_valid0, out_data0, out_lane0, out_last0, fc0);
    end
    n_tests++;
    if ({out_valid1, out_data1, out_lane1, out_last1, fc1} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 got v=%b d=%h l=%b last=%b fc=%0d want all zero",
               out_valid1, out_data1, out_lane1, out_last1, fc1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({in_ready0, in_ready1, out_valid0, out_valid1} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b%b v=%b%b want rdy=11 v=00",
               in_ready0, in_ready1, out_valid0, out_valid1);
    end
  endtask

  task automatic test_bf16_order();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    push(32'h3F80_4000, FP16, 5, ok);
    repeat (4) @(negedge clk);
    n_tests++;
    if (obs0.size() != 2 || obs0[0] !== {2'b00, 32'h4000_0000} ||
        obs0[1] !== {2'b11, 32'h3F80_0000}) begin
      n_fail++;
      $display("FAIL bf16_lo_first got n=%0d b0=%h b1=%h want 0_4000_0000 3_3F80_0000",
               obs0.size(), obs0.size() > 0 ? obs0[0] : 34'h0, obs0.size() > 1 ? obs0[1] : 34'h0);
    end
    n_tests++;
    if (obs1.size() != 2 || obs1[0] !== {2'b10, 32'h3F80_0000} ||
        obs1[1] !== {2'b01, 32'h4000_0000}) begin
      n_fail++;
      $display("FAIL bf16_hi_first got n=%0d b0=%h b1=%h want 2_3F80_0000 1_4000_0000",
               obs1.size(), obs1.size() > 0 ? obs1[0] : 34'h0, obs1.size() > 1 ? obs1[1] : 34'h0);
    end
  endtask

  task automatic test_fp32_latency();
    clear_logs();
    out_ready = 1'b1;
    in_data = 32'h4049_0FDB; in_fmt = FP32; v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    n_tests++;
    if (out_valid0 !== 1'b0 || fc0 !== 2'd1 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_after_accept got v0=%b fc0=%0d v1=%b want 0 1 0", out_valid0, fc0, out_valid1);
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid0, out_data0, out_lane0, out_last0} !== {1'b1, 32'h4049_0FDB, 2'b01}) begin
      n_fail++;
      $display("FAIL lat_beat_dut0 got v=%b d=%h l=%b last=%b want 1 4049_0fdb 0 1",
               out_valid0, out_data0, out_lane0, out_last0);
    end
    n_tests++;
    if ({out_valid1, out_data1, out_lane1, out_last1} !== {1'b1, 32'h4049_0FDB, 2'b01}) begin
      n_fail++;
      $display("FAIL lat_beat_dut1 got v=%b d=%h l=%b last=%b want 1 4049_0fdb 0 1",
               out_valid1, out_data1, out_lane1, out_last1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h1000 + i, FP32, 5, ok);
    repeat (5) @(negedge clk);
    n_tests++;
    if (ts0.size() != 3 || ts0[2] - ts0[0] != 2) begin
      n_fail++;
      $display("FAIL b2b_rate got beats=%0d span=%0d want 3 beats span 2",
               ts0.size(), ts0.size() == 3 ? ts0[2] - ts0[0] : -1);
    end
    for (int i = 0; i < obs0.size() && i < 3; i++) begin
      n_tests++;
      if (obs0[i] !== {2'b01, 32'h1000 + i}) begin
        n_fail++;
        $display("FAIL b2b_data[%0d] got %h want %h", i, obs0[i], {2'b01, 32'h1000 + i});
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(i, FP32, 3, ok);
    n_tests++;
    if (acc0.size() != 3 || in_ready0 !== 1'b0 || fc0 !== 2'd2 || v0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full got acc=%0d rdy=%b fc=%0d pend=%b want 3 0 2 1",
               acc0.size(), in_ready0, fc0, v0);
    end
    n_tests++;
    if (acc1.size() != 4 || fc1 !== 3'd3) begin
      n_fail++;
      $display("FAIL bp_dut1 got acc=%0d fc=%0d want 4 3", acc1.size(), fc1);
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h want 1 00000001", c, out_valid0, out_data0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    finish_push(10, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_fourth_accept got pending=%b want 0", v0);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs0.size() != 4 || obs0[i] !== {2'b01, 32'(i + 1)}) begin
        n_fail++;
        $display("FAIL bp_order[%0d] got n=%0d b=%h want %h", i, obs0.size(),
                 i < obs0.size() ? obs0[i] : 34'h0, {2'b01, 32'(i + 1)});
      end
    end
  endtask

  task automatic test_stall_pair();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    push(32'hC000_3F80, FP16, 5, ok);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (fc0 !== 2'd1 || out_valid0 !== 1'b1 || out_data0 !== 32'h3F80_0000 || out_last0 !== 1'b0 ||
          fc1 !== 3'd1 || out_data1 !== 32'hC000_0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got fc0=%0d v0=%b d0=%h last0=%b fc1=%0d d1=%h want 1 1 3f800000 0 1 c0000000",
                 c, fc0, out_valid0, out_data0, out_last0, fc1, out_data1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (obs0.size() != 2 || obs0[0] !== {2'b00, 32'h3F80_0000} || obs0[1] !== {2'b11, 32'hC000_0000}) begin
      n_fail++;
      $display("FAIL stall_release_dut0 got n=%0d last=%h want 2 beats ending 3_c0000000",
               obs0.size(), obs0.size() > 0 ? obs0[obs0.size()-1] : 34'h0);
    end
    n_tests++;
    if (obs1.size() != 2 || obs1[0] !== {2'b10, 32'hC000_0000} || obs1[1] !== {2'b01, 32'h3F80_0000}) begin
      n_fail++;
      $display("FAIL stall_release_dut1 got n=%0d last=%h want 2 beats ending 1_3f800000",
               obs1.size(), obs1.size() > 0 ? obs1[obs1.size()-1] : 34'h0);
    end
  endtask

  task automatic test_nan();
    bit ok;
    logic [31:0] want_hi;
`ifdef FP_UNPACK_NAN_CANON_EN
    want_hi = 32'h7FC0_0000;
`else
    want_hi = 32'h7F81_0000;
`endif
    clear_logs();
    out_ready = 1'b1;
    push(32'h7F81_0001, FP16, 5, ok);
    push(32'h7F80_0001, FP32, 5, ok);
    push(32'hFF80_0000, FP32, 5, ok);
    repeat (6) @(negedge clk);
    n_tests++;
    if (obs0.size() != 4 || obs0[0] !== {2'b00, 32'h0001_0000} || obs0[1] !== {2'b11, want_hi}) begin
      n_fail++;
      $display("FAIL nan_pair got n=%0d b0=%h b1=%h want 0_00010000 3_%h", obs0.size(),
               obs0.size() > 0 ? obs0[0] : 34'h0, obs0.size() > 1 ? obs0[1] : 34'h0, want_hi);
    end
    build_exp(1);
    n_tests++;
    if (obs1 != exp_q) begin
      n_fail++;
      $display("FAIL nan_dut1 got n=%0d want n=%0d or contents differ", obs1.size(), exp_q.size());
    end
    n_tests++;
    if (obs0.size() == 4 && obs0[3] !== {2'b01, 32'hFF80_0000}) begin
      n_fail++;
      $display("FAIL nan_inf got %h want 1_ff800000", obs0[3]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    push(32'h1234_5678, FP16, 5, ok);
    push(32'hAAAA_5555, FP32, 5, ok);
    @(negedge clk);
    n_tests++;
    if (out_valid0 !== 1'b1 || out_last0 !== 1'b0 || fc0 !== 2'd2) begin
      n_fail++;
      $display("FAIL rmid_setup got v=%b last=%b fc=%0d want 1 0 2", out_valid0, out_last0, fc0);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid0 !== 1'b0 || fc0 !== 2'd0 || out_valid1 !== 1'b0 || fc1 !== 3'd0 || out_data0 !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_async got v0=%b fc0=%0d v1=%b fc1=%0d d0=%h want 0 0 0 0 0",
               out_valid0, fc0, out_valid1, fc1, out_data0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (obs0.size() != 0 || obs1.size() != 0 || out_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_stale got beats0=%0d beats1=%0d v0=%b want 0 0 0", obs0.size(), obs1.size(), out_valid0);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] d;
    clear_logs();
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      d = $urandom;
      if ($urandom_range(0, 4) == 0) d[30:23] = 8'hFF;
      if ($urandom_range(0, 4) == 0) d[14:7] = 8'hFF;
      push(d, fp_fmt_e'(3'($urandom_range(0, 4))), 200, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_push[%0d] got pending=%b%b want accepted", i, v0, v1);
        v0 = 1'b0; v1 = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    build_exp(0);
    n_tests++;
    if (obs0.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count_dut0 got %0d want %0d", obs0.size(), exp_q.size());
    end
    for (int i = 0; i < obs0.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs0[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_beat_dut0[%0d] got %h want %h", i, obs0[i], exp_q[i]);
      end
    end
    build_exp(1);
    n_tests++;
    if (obs1.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count_dut1 got %0d want %0d", obs1.size(), exp_q.size());
    end
    for (int i = 0; i < obs1.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs1[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_beat_dut1[%0d] got %h want %h", i, obs1[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bf16_order();
    test_fp32_latency();
    test_back_to_back();
    test_backpressure();
    test_stall_pair();
    test_nan();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout got no finish want finish before 500us");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_result_unpacker.md
Name: fp_result_unpacker

Overview:
Streaming consumer on the result side of the FP32/2xBF16 SIMD adder.
- Accepts packed 32-bit result words tagged with fp_fmt_e through a valid/ready input FIFO.
- Serialises each word into scalar FP32 beats on a valid/ready output: one beat for FP32, two beats for a packed BF16 pair.
- BF16 lanes are widened exactly to FP32.
- Sits between the add datapath and scalar writeback or scalar check logic.

Parameters:
DEPTH, 2, input FIFO entries; power of two, ≥2.
LANE_ORDER, 0, BF16 beat order: 0 = low lane [15:0] first, 1 = high lane [31:16] first.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  FIFO can accept; equals (fifo_count < DEPTH), no same-cycle pop bypass
in_fmt  input  fp_fmt_e  FP32 = one scalar; FP16 = two BF16 lanes
in_data  input  32  packed result word
out_valid  output  1  output beat valid (registered)
out_ready  input  1  downstream accepts beat
out_data  output  32  FP32 scalar (registered)
out_lane  output  1  0 = from [15:0] or FP32, 1 = from [31:16]
out_last  output  1  final beat of the current word
fifo_count  output  $clog2(DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset values: out_valid=0, out_data=0, out_lane=0, out_last=0, fifo_count=0, FSM=IDLE. in_ready=1 while rst is low after reset.
- Push: an entry {in_fmt, in_data} is written when in_valid & in_ready at the rising edge. A push to a full FIFO is impossible because in_ready=0.
- Output register load condition: load = !out_valid | out_ready. Held data (out_data, out_lane, out_last) is stable while out_valid & !out_ready.
- FSM states: IDLE, FIRST, SECOND.
- IDLE/FIRST, on load with FIFO non-empty:
  - Head is FP32: out_data=head.data, lane=0, last=1. Pop the head. Stay in FIRST.
  - Head is FP16: emit the first lane per LANE_ORDER, last=0. Do not pop. Go to SECOND.
- SECOND, on load: emit the other lane, last=1. Pop the head. Go to FIRST.
- FIRST with FIFO empty and load: out_valid←0. Go to IDLE.
- Widening: lane L (16 bits) → {L, 16'h0000}. Bit-exact, no rounding, sign preserved.
- Latency: a word accepted at edge k into an empty block gives out_valid=1 after edge k+1. A continuous stream with out_ready=1 sustains 1 beat/cycle.
- Simultaneous push and pop in one cycle: fifo_count unchanged. Pointers wrap modulo DEPTH.
- The head entry is popped only when its last beat loads. A BF16 pair therefore occupies its FIFO slot until its second beat is in the output register.
- Reset mid-pair: the pending second lane and all FIFO contents are discarded. Outputs return to reset values asynchronously.
- fp_fmt_e values other than FP32 are treated as FP16 (packed pair).

Optional Feature:
FP_UNPACK_NAN_CANON_EN
- Defined: any output beat whose widened value is NaN (exp=8'hFF, frac≠0) is replaced by 32'h7FC00000. Applies to both FP32 and BF16 beats. Infinities are untouched. No added latency.
- Undefined: out_data is bit-exact (FP32 passthrough, BF16 zero-extended).

Test Plan:
- BF16 ordering: LANE_ORDER=0, push fmt=FP16, data=32'h3F80_4000, out_ready=1 → beat1 32'h4000_0000 lane0 last0; beat2 32'h3F80_0000 lane1 last1. Rerun with LANE_ORDER=1 → order reversed.
- FP32 passthrough: push fmt=FP32, 32'h4049_0FDB → one beat 32'h4049_0FDB lane0 last1, out_valid one cycle after accept edge +1. Back-to-back FP32 words with out_ready=1 give 1 beat/cycle.
- Backpressure, DEPTH=2, out_ready=0: push four FP32 words 1,2,3,4 → three accepted (one in the output register, two in the FIFO). in_ready=0 on the fourth. out_data holds word 1 stable. Release out_ready → beats 1,2,3 in order, then word 4 accepted.
- Stall mid-pair: push 32'hC000_3F80 (FP16), drop out_ready after beat1 for 3 cycles → fifo_count stays 1, beat2 32'hC000_0000 appears on release with last1.
- NaN: push FP16 32'h7F81_0001 → without macro, beats 32'h0001_0000 and 32'h7F81_0000. With FP_UNPACK_NAN_CANON_EN, second beat is 32'h7FC0_0000.
- Reset mid-operation: assert rst between beat1 and beat2 of a pair with 1 word queued → out_valid=0 immediately, fifo_count=0, and no stale beat after release.
